sar_result_avg_fifo: RTL and testbench
======================================

// Module: sar_result_avg_fifo
// PURPOSE
//   Downstream consumer of the 10-bit coarse/fine SAR logic. Captures sar[] on each rising
//   edge of eoc and optionally averages 2^LOG2_AVG conversions (oversampling). Results are
//   buffered in a small FIFO and presented on a valid/ready stream to the digital back end.
//   Sits between the SAR logic and the system bus / DSP.
// PARAMETERS
//   DATA_W      10  width of sar[] and out_data[]
//   LOG2_AVG    2   log2 of samples per averaged result; legal range 0..4 (0 = pass-through)
//   FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//   clk         in   1                    system clock, same domain as the SAR logic
//   rst         in   1                    asynchronous, active-low reset
//   sar         in   DATA_W               conversion result from SAR logic
//   eoc         in   1                    end of conversion; level held high while sar[] is valid
//   enable      in   1                    capture enable; 0 = ignore eoc and discard partial sum
//   out_data    out  DATA_W               FIFO head (averaged result)
//   out_valid   out  1                    FIFO non-empty
//   out_ready   in   1                    consumer accepts out_data when valid&ready
//   fifo_level  out  $clog2(FIFO_DEPTH)+1 entries currently held
//   ovf         out  1                    sticky overflow: a result was dropped because FIFO was full
//   clr_ovf     in   1                    synchronous clear of ovf
// BEHAVIOUR
//   - Reset (rst=0, async): eoc_d=0, acc=0, cnt=0, FIFO empty, out_valid=0, out_data=0,
//     fifo_level=0, ovf=0. Reset mid-accumulation or mid-stream discards everything.
//   - Capture event cap = eoc & ~eoc_d & enable, evaluated on each rising clk; eoc_d <= eoc.
//     eoc held high for many cycles yields exactly one capture.
//   - Accumulator: ACC_W = DATA_W+LOG2_AVG, unsigned, never overflows.
//     FSM states ACCUM (cnt < 2^LOG2_AVG-1) and LAST (cnt == 2^LOG2_AVG-1):
//       cap in ACCUM: acc <= acc+sar, cnt <= cnt+1.
//       cap in LAST : push ((acc+sar) >> LOG2_AVG) (truncating), acc <= 0, cnt <= 0.
//     LOG2_AVG=0: always LAST; every capture pushes sar unchanged.
//   - enable=0: acc <= 0, cnt <= 0 every cycle; FIFO contents and ovf unaffected.
//   - Latency: push at the capture edge; out_valid and out_data reflect the new entry
//     immediately after that edge (1 clk from the eoc rise being sampled).
//   - Pop: at the edge where out_valid & out_ready; head advances and out_data updates
//     after that edge.
//   - Full FIFO + push without pop: result dropped, FIFO unchanged, ovf <= 1.
//     Full FIFO + push + pop in the same cycle: both occur, level stays FULL, no ovf.
//   - Empty FIFO + pop: impossible (out_valid=0). Push + pop on empty: push only.
//   - Pointer wrap: read/write pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty come from
//     the MSB compare; the counters wrap modulo 2*FIFO_DEPTH.
//   - clr_ovf and a new overflow in the same cycle: ovf stays 1 (set wins).
//   - out_data is registered from FIFO storage; it is not 0 while out_valid=0 after the
//     first entry (holds the last head). Benches check it only when valid.
// STRUCTURE
//   - Shared package sar_pkg: SAR_W=10 constant, acc/pointer width functions, and the
//     state enum {ACCUM, LAST} if the SV flow is used.
//   - One sub-module: sar_sync_fifo (DATA_W, FIFO_DEPTH; push/pop/full/empty/level).
//     The top holds the edge detector, accumulator FSM and ovf logic.
// TESTING
//   1 LOG2_AVG=0, eoc pulses with sar=10'h155, then 10'h2AA, out_ready=1 -> out_data 155
//     then 2AA, each valid 1 clk after its eoc rise; fifo_level returns to 0.
//   2 LOG2_AVG=2, four captures 100,101,102,103 (dec) -> single push out_data=101
//     (406>>2); no output after the first three captures.
//   3 eoc held high for 20 clks with enable=1 -> exactly one capture (cnt increments by 1).
//   4 out_ready=0, LOG2_AVG=0, 5 captures into DEPTH=4 -> level=4, ovf=1, entries 1..4
//     kept and the 5th dropped; then clr_ovf -> ovf=0; drain -> 4 values in order.
//   5 FIFO full, out_ready=1 while a capture occurs -> level stays 4, ovf stays 0,
//     head advances.
//   6 rst low after 2 of 4 averaging captures with 2 FIFO entries -> out_valid=0, level=0,
//     ovf=0 at once (async); the next 4 captures average cleanly with no residue.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared constants, width helpers and state type for the SAR result path.
package sar_pkg;

    localparam int SAR_W = 10;

    typedef enum logic {
        ACCUM,
        LAST
    } avg_state_e;

    function automatic int acc_w(input int data_w, input int log2_avg);
        return data_w + log2_avg;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Synchronous result FIFO with a registered head word and wrap-bit pointers.
module sar_sync_fifo
    import sar_pkg::*;
#(
    parameter int DATA_W     = SAR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    input  logic                          pop,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = ptr_w(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_nxt;
    logic [DATA_W-1:0] head_nxt;
    logic              do_pop;
    logic              do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_nxt  = rd_ptr + PW'(1);

    // Head is kept in a register, so look ahead to what it becomes.
    always_comb begin
        head_nxt = dout;
        if (do_pop) begin
            if (rd_nxt != wr_ptr)
                head_nxt = mem[rd_nxt[AW-1:0]];
            else if (do_push)
                head_nxt = din;
        end else if (empty && do_push) begin
            head_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_nxt;
            dout <= head_nxt;
        end
    end

endmodule

// File: rtl/sar_result_avg_fifo.sv
// Captures SAR results on eoc rise, averages 2^LOG2_AVG of them, streams via FIFO.
module sar_result_avg_fifo
    import sar_pkg::*;
#(
    parameter int DATA_W     = SAR_W,
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           sar,
    input  logic                        eoc,
    input  logic                        enable,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf,
    input  logic                        clr_ovf
);

    localparam int ACC_W = acc_w(DATA_W, LOG2_AVG);
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam avg_state_e ST_INIT = (LOG2_AVG == 0) ? LAST : ACCUM;

    avg_state_e        state;
    avg_state_e        state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              eoc_d;
    logic              cap;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              full;
    logic              empty;

    assign cap       = eoc & ~eoc_d & enable;
    assign sum       = acc + ACC_W'(sar);
    assign push_data = DATA_W'(sum >> LOG2_AVG);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        push      = 1'b0;
        if (!enable) begin
            state_nxt = ST_INIT;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (cap) begin
            unique case (state)
                ACCUM: begin
                    acc_nxt   = sum;
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = (cnt_nxt == CNT_LAST) ? LAST : ACCUM;
                end
                LAST: begin
                    push      = 1'b1;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            acc   <= '0;
            cnt   <= '0;
            eoc_d <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            eoc_d <= eoc;
            // A fresh drop outranks a clear in the same cycle.
            if (push && full && !pop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    sar_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_sar_result_avg_fifo.sv
// Directed bench: pass-through instance (LOG2_AVG=0) and averaging instance (LOG2_AVG=2).
module tb_sar_result_avg_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sar;
    logic       eoc;
    logic       clr_ovf;
    logic       en0, en2;
    logic       rdy0, rdy2;
    logic [9:0] data0, data2;
    logic       valid0, valid2;
    logic [2:0] level0, level2;
    logic       ovf0, ovf2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sar_result_avg_fifo #(.DATA_W(10), .LOG2_AVG(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .sar(sar), .eoc(eoc), .enable(en0),
        .out_data(data0), .out_valid(valid0), .out_ready(rdy0),
        .fifo_level(level0), .ovf(ovf0), .clr_ovf(clr_ovf)
    );

    sar_result_avg_fifo #(.DATA_W(10), .LOG2_AVG(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .sar(sar), .eoc(eoc), .enable(en2),
        .out_data(data2), .out_valid(valid2), .out_ready(rdy2),
        .fifo_level(level2), .ovf(ovf2), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise eoc with a value; returns just after the capture edge.
    task automatic rise(input logic [9:0] v);
        sar = v;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
    endtask

    task automatic pulse(input logic [9:0] v);
        rise(v);
        tick();
    endtask

    initial begin
        rst = 1'b0; sar = '0; eoc = 1'b0; clr_ovf = 1'b0;
        en0 = 1'b0; en2 = 1'b0; rdy0 = 1'b0; rdy2 = 1'b0;
        #12;
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_data0",  32'(data0),  32'd0);
        chk("rst_level0", 32'(level0), 32'd0);
        chk("rst_ovf0",   32'(ovf0),   32'd0);
        chk("rst_valid2", 32'(valid2), 32'd0);
        rst = 1'b1;
        tick();

        // 1: pass-through, immediate drain
        en0 = 1'b1; rdy0 = 1'b1;
        rise(10'h155);
        chk("t1_valid_a", 32'(valid0), 32'd1);
        chk("t1_data_a",  32'(data0),  32'h155);
        tick();
        chk("t1_level_a", 32'(level0), 32'd0);
        rise(10'h2AA);
        chk("t1_valid_b", 32'(valid0), 32'd1);
        chk("t1_data_b",  32'(data0),  32'h2AA);
        tick();
        chk("t1_level_b", 32'(level0), 32'd0);
        chk("t1_valid_c", 32'(valid0), 32'd0);
        en0 = 1'b0; rdy0 = 1'b0;

        // 2: average of 100..103
        en2 = 1'b1;
        pulse(10'd100);
        chk("t2_novalid1", 32'(valid2), 32'd0);
        pulse(10'd101);
        pulse(10'd102);
        chk("t2_novalid3", 32'(valid2), 32'd0);
        rise(10'd103);
        chk("t2_valid", 32'(valid2), 32'd1);
        chk("t2_data",  32'(data2),  32'd101);
        chk("t2_level", 32'(level2), 32'd1);
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        chk("t2_drained", 32'(level2), 32'd0);

        // 3: long eoc high is a single capture
        sar = 10'd40;
        eoc = 1'b1;
        repeat (20) tick();
        eoc = 1'b0;
        tick();
        chk("t3_nopush", 32'(valid2), 32'd0);
        pulse(10'd0);
        pulse(10'd0);
        chk("t3_novalid", 32'(valid2), 32'd0);
        rise(10'd0);
        chk("t3_valid", 32'(valid2), 32'd1);
        chk("t3_data",  32'(data2),  32'd10);
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        en2 = 1'b0;

        // 4: overflow, clear, ordered drain
        en0 = 1'b1;
        for (int i = 1; i <= 4; i++) pulse(10'(i));
        chk("t4_full_level", 32'(level0), 32'd4);
        chk("t4_no_ovf",     32'(ovf0),   32'd0);
        pulse(10'd5);
        chk("t4_level", 32'(level0), 32'd4);
        chk("t4_ovf",   32'(ovf0),   32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_clr", 32'(ovf0), 32'd0);
        rdy0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_drain", 32'(data0), 32'(i));
            tick();
        end
        chk("t4_empty", 32'(valid0), 32'd0);
        rdy0 = 1'b0;

        // 5: push and pop together on a full FIFO
        for (int i = 11; i <= 14; i++) pulse(10'(i));
        chk("t5_full", 32'(level0), 32'd4);
        sar = 10'd15;
        eoc = 1'b1;
        rdy0 = 1'b1;
        tick();
        eoc = 1'b0;
        rdy0 = 1'b0;
        chk("t5_level", 32'(level0), 32'd4);
        chk("t5_ovf",   32'(ovf0),   32'd0);
        chk("t5_head",  32'(data0),  32'd12);
        tick();
        rdy0 = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            chk("t5_drain", 32'(data0), 32'(i));
            tick();
        end
        rdy0 = 1'b0;

        // 6: async reset mid-accumulation and mid-stream
        for (int i = 0; i < 5; i++) pulse(10'd1);
        chk("t6_pre_ovf0", 32'(ovf0), 32'd1);
        en0 = 1'b0;
        en2 = 1'b1;
        for (int i = 0; i < 8; i++) pulse(10'd4);
        chk("t6_pre_level2", 32'(level2), 32'd2);
        chk("t6_pre_data2",  32'(data2),  32'd4);
        pulse(10'd1000);
        pulse(10'd1000);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_valid2", 32'(valid2), 32'd0);
        chk("t6_level2", 32'(level2), 32'd0);
        chk("t6_data2",  32'(data2),  32'd0);
        chk("t6_ovf0",   32'(ovf0),   32'd0);
        chk("t6_level0", 32'(level0), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        pulse(10'd200);
        pulse(10'd201);
        pulse(10'd202);
        chk("t6_novalid", 32'(valid2), 32'd0);
        rise(10'd203);
        chk("t6_avg",   32'(data2),  32'd201);
        chk("t6_level", 32'(level2), 32'd1);
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;

        // enable low discards a partial sum
        pulse(10'd500);
        pulse(10'd500);
        en2 = 1'b0;
        tick();
        en2 = 1'b1;
        for (int i = 0; i < 3; i++) pulse(10'd8);
        chk("en_novalid", 32'(valid2), 32'd0);
        rise(10'd8);
        chk("en_avg", 32'(data2), 32'd8);
        chk("en_ovf2", 32'(ovf2), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
